// File: rtl/multi_alarm_clock_core_if.sv
// Bundle between the switch/debounce controller and the timekeeping core:
// mode/edit/ring-control pulses in, display value, tick and buzzer status out.
interface multi_alarm_clock_core_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic [1:0]            i_mode;
    logic [1:0]            i_position;
    logic                  i_inc;
    logic [IW-1:0]         i_alarm_sel;
    logic                  i_alarm_toggle;
    logic                  i_snooze;
    logic                  i_stop;
    logic [5:0]            o_hour;
    logic [5:0]            o_min;
    logic [5:0]            o_sec;
    logic                  o_tick;
    logic                  o_alarm_ring;
    logic [IW-1:0]         o_ring_idx;
    logic [NUM_ALARMS-1:0] o_alarm_en;

    modport master (
        output i_mode, i_position, i_inc, i_alarm_sel, i_alarm_toggle, i_snooze, i_stop,
        input  o_hour, o_min, o_sec, o_tick, o_alarm_ring, o_ring_idx, o_alarm_en
    );

    modport slave (
        input  i_mode, i_position, i_inc, i_alarm_sel, i_alarm_toggle, i_snooze, i_stop,
        output o_hour, o_min, o_sec, o_tick, o_alarm_ring, o_ring_idx, o_alarm_en
    );
endinterface

// File: rtl/multi_alarm_clock_core.sv
// Timekeeping core: 1 Hz prescaler, HH:MM:SS counter, NUM_ALARMS editable alarms,
// and a ring controller with snooze and an auto-timeout.
module multi_alarm_clock_core #(
    parameter int CLK_HZ     = 1000,
    parameter int NUM_ALARMS = 4,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60
) (
    input  logic clk,
    input  logic rst_n,
    multi_alarm_clock_core_if.slave bus
);
    localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
    localparam int PW = $clog2(CLK_HZ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RING    = 2'd1,
        SNOOZED = 2'd2
    } ring_state_t;

    logic [PW-1:0]         pre_cnt;
    logic [5:0]            cur_hour, cur_min, cur_sec;
    logic [5:0]            nxt_hour, nxt_min, nxt_sec;
    logic [5:0]            alarm_hour [NUM_ALARMS];
    logic [5:0]            alarm_min  [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] alarm_en;

    ring_state_t           state, state_next;
    logic [7:0]            ring_cnt, ring_cnt_next;
    logic [IW-1:0]         ring_idx, ring_idx_next;
    logic [5:0]            snz_hour, snz_min, snz_hour_next, snz_min_next;

    logic                  set_time, set_alarm, running, tick;
    logic                  sel_valid, hit, trigger, snooze_due;
    logic [5:0]            sel_hour, sel_min;
    logic [IW-1:0]         hit_idx;
    logic [6:0]            snz_sum;
    logic [5:0]            tgt_hour, tgt_min;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
        return (v == top) ? 6'd0 : v + 6'd1;
    endfunction

    // Mode 3 behaves exactly like mode 0.
    assign set_time  = (bus.i_mode == 2'd1);
    assign set_alarm = (bus.i_mode == 2'd2);
    assign running   = !set_time;
    assign tick      = running && (pre_cnt == PW'(CLK_HZ - 1));

    always_comb begin
        nxt_hour = cur_hour;
        nxt_min  = cur_min;
        nxt_sec  = cur_sec;
        if (tick) begin
            nxt_sec = wrap_inc(cur_sec, 6'd59);
            if (cur_sec == 6'd59) begin
                nxt_min = wrap_inc(cur_min, 6'd59);
                if (cur_min == 6'd59)
                    nxt_hour = wrap_inc(cur_hour, 6'd23);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_hour  = 6'd0;
        sel_min   = 6'd0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (bus.i_alarm_sel == IW'(i)) begin
                sel_valid = 1'b1;
                sel_hour  = alarm_hour[i];
                sel_min   = alarm_min[i];
            end
        end
    end

    // Scanning downwards leaves the lowest matching index as the winner.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (alarm_en[i] && alarm_hour[i] == nxt_hour && alarm_min[i] == nxt_min) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign trigger    = tick && (nxt_sec == 6'd0) && hit;
    assign snooze_due = tick && (nxt_sec == 6'd0) && (nxt_min == snz_min) && (nxt_hour == snz_hour);

    always_comb begin
        snz_sum  = {1'b0, cur_min} + 7'(SNOOZE_MIN);
        tgt_hour = cur_hour;
        tgt_min  = snz_sum[5:0];
        if (snz_sum >= 7'd60) begin
            tgt_min  = 6'(snz_sum - 7'd60);
            tgt_hour = wrap_inc(cur_hour, 6'd23);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            cur_hour <= 6'd0;
            cur_min  <= 6'd0;
            cur_sec  <= 6'd0;
            alarm_en <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarm_hour[i] <= 6'd0;
                alarm_min[i]  <= 6'd0;
            end
        end else begin
            if (!running || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + 1'b1;

            if (tick) begin
                cur_hour <= nxt_hour;
                cur_min  <= nxt_min;
                cur_sec  <= nxt_sec;
            end else if (set_time && bus.i_inc) begin
                case (bus.i_position)
                    2'd0:    cur_sec  <= wrap_inc(cur_sec, 6'd59);
                    2'd1:    cur_min  <= wrap_inc(cur_min, 6'd59);
                    2'd2:    cur_hour <= wrap_inc(cur_hour, 6'd23);
                    default: ;
                endcase
            end

            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (set_alarm && bus.i_alarm_sel == IW'(i)) begin
                    if (bus.i_inc && bus.i_position == 2'd1)
                        alarm_min[i] <= wrap_inc(alarm_min[i], 6'd59);
                    if (bus.i_inc && bus.i_position == 2'd2)
                        alarm_hour[i] <= wrap_inc(alarm_hour[i], 6'd23);
                    if (bus.i_alarm_toggle)
                        alarm_en[i] <= ~alarm_en[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ring_cnt <= 8'd0;
            ring_idx <= '0;
            snz_hour <= 6'd0;
            snz_min  <= 6'd0;
        end else begin
            state    <= state_next;
            ring_cnt <= ring_cnt_next;
            ring_idx <= ring_idx_next;
            snz_hour <= snz_hour_next;
            snz_min  <= snz_min_next;
        end
    end

    // Stop beats snooze; a fresh alarm match beats a pending snooze.
    always_comb begin
        state_next    = state;
        ring_cnt_next = ring_cnt;
        ring_idx_next = ring_idx;
        snz_hour_next = snz_hour;
        snz_min_next  = snz_min;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next    = RING;
                    ring_cnt_next = 8'd0;
                    ring_idx_next = hit_idx;
                end
            end
            RING: begin
                if (bus.i_stop) begin
                    state_next = IDLE;
                end else if (bus.i_snooze) begin
                    state_next    = SNOOZED;
                    snz_hour_next = tgt_hour;
                    snz_min_next  = tgt_min;
                end else if (tick) begin
                    if (ring_cnt + 8'd1 == 8'(RING_SEC))
                        state_next = IDLE;
                    else
                        ring_cnt_next = ring_cnt + 8'd1;
                end
            end
            SNOOZED: begin
                if (bus.i_stop) begin
                    state_next = IDLE;
                end else if (trigger) begin
                    state_next    = RING;
                    ring_cnt_next = 8'd0;
                    ring_idx_next = hit_idx;
                end else if (snooze_due) begin
                    state_next    = RING;
                    ring_cnt_next = 8'd0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.o_hour = cur_hour;
        bus.o_min  = cur_min;
        bus.o_sec  = cur_sec;
        if (set_alarm) begin
            bus.o_hour = sel_valid ? sel_hour : 6'd0;
            bus.o_min  = sel_valid ? sel_min  : 6'd0;
            bus.o_sec  = 6'd0;
        end
    end

    assign bus.o_tick       = tick;
    assign bus.o_alarm_ring = (state == RING);
    assign bus.o_ring_idx   = ring_idx;
    assign bus.o_alarm_en   = alarm_en;
endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Directed bench for multi_alarm_clock_core: a seconds-of-day reference model
// checked every cycle, plus hand-computed checkpoints for each scenario.
module tb_multi_alarm_clock_core;
    localparam int CLK_HZ     = 4;
    localparam int NA         = 4;
    localparam int SNOOZE_MIN = 5;
    localparam int RING_SEC   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multi_alarm_clock_core_if #(.NUM_ALARMS(NA)) bus ();

    multi_alarm_clock_core #(
        .CLK_HZ(CLK_HZ), .NUM_ALARMS(NA), .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: time and alarms in seconds/minutes of the day.
    bit model_valid = 1'b0;
    int m_pre, m_time, m_ring_secs, m_idx, m_target;
    int m_al [NA];
    bit m_en [NA];
    bit m_ringing, m_pending;

    task automatic modelStep();
        int mode, old_time, new_time, hit, h, mi, s;
        bit tick;
        mode     = (bus.i_mode == 2'd3) ? 0 : int'(bus.i_mode);
        tick     = (mode != 1) && (m_pre == CLK_HZ - 1);
        old_time = m_time;
        new_time = tick ? (m_time + 1) % 86400 : m_time;
        hit = -1;
        if (tick && new_time % 60 == 0)
            for (int i = NA - 1; i >= 0; i--)
                if (m_en[i] && m_al[i] * 60 == new_time) hit = i;

        if (m_ringing) begin
            if (bus.i_stop) m_ringing = 0;
            else if (bus.i_snooze) begin
                m_ringing = 0;
                m_pending = 1;
                m_target  = ((old_time / 60 + SNOOZE_MIN) % 1440) * 60;
            end else if (tick) begin
                m_ring_secs++;
                if (m_ring_secs == RING_SEC) m_ringing = 0;
            end
        end else if (m_pending) begin
            if (bus.i_stop) m_pending = 0;
            else if (hit >= 0) begin
                m_ringing = 1; m_pending = 0; m_idx = hit; m_ring_secs = 0;
            end else if (tick && new_time == m_target) begin
                m_ringing = 1; m_pending = 0; m_ring_secs = 0;
            end
        end else if (hit >= 0) begin
            m_ringing = 1; m_idx = hit; m_ring_secs = 0;
        end

        if (mode == 1) begin
            m_pre = 0;
            if (bus.i_inc) begin
                h  = m_time / 3600;
                mi = (m_time / 60) % 60;
                s  = m_time % 60;
                if (bus.i_position == 2'd0) s  = (s + 1) % 60;
                if (bus.i_position == 2'd1) mi = (mi + 1) % 60;
                if (bus.i_position == 2'd2) h  = (h + 1) % 24;
                m_time = h * 3600 + mi * 60 + s;
            end
        end else begin
            m_pre  = (m_pre + 1) % CLK_HZ;
            m_time = new_time;
        end

        if (mode == 2 && int'(bus.i_alarm_sel) < NA) begin
            h  = m_al[bus.i_alarm_sel] / 60;
            mi = m_al[bus.i_alarm_sel] % 60;
            if (bus.i_inc && bus.i_position == 2'd1) mi = (mi + 1) % 60;
            if (bus.i_inc && bus.i_position == 2'd2) h  = (h + 1) % 24;
            m_al[bus.i_alarm_sel] = h * 60 + mi;
            if (bus.i_alarm_toggle) m_en[bus.i_alarm_sel] = !m_en[bus.i_alarm_sel];
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_pre = 0; m_time = 0; m_ring_secs = 0; m_idx = 0; m_target = 0;
            m_ringing = 0; m_pending = 0;
            for (int i = 0; i < NA; i++) begin
                m_al[i] = 0;
                m_en[i] = 0;
            end
            model_valid = 1'b1;
        end else if (model_valid) begin
            modelStep();
        end
    end

    // Every-cycle comparison of all outputs against the reference.
    initial forever begin
        int eh, em, es, etick, eidx, een;
        @(negedge clk);
        if (model_valid) begin
            if (bus.i_mode == 2'd2) begin
                eh = (int'(bus.i_alarm_sel) < NA) ? m_al[bus.i_alarm_sel] / 60 : 0;
                em = (int'(bus.i_alarm_sel) < NA) ? m_al[bus.i_alarm_sel] % 60 : 0;
                es = 0;
            end else begin
                eh = m_time / 3600;
                em = (m_time / 60) % 60;
                es = m_time % 60;
            end
            etick = (bus.i_mode != 2'd1 && m_pre == CLK_HZ - 1) ? 1 : 0;
            eidx  = m_idx;
            een   = 0;
            for (int i = 0; i < NA; i++) if (m_en[i]) een += (1 << i);
            checks++;
            if (int'(bus.o_hour) != eh || int'(bus.o_min) != em || int'(bus.o_sec) != es ||
                int'(bus.o_tick) != etick || bus.o_alarm_ring !== m_ringing ||
                int'(bus.o_ring_idx) != eidx || int'(bus.o_alarm_en) != een) begin
                errors++;
                $display("[TB] FAIL cycle_outputs t=%0t got %0d:%0d:%0d tick=%0d ring=%0d idx=%0d en=%0d expected %0d:%0d:%0d tick=%0d ring=%0d idx=%0d en=%0d",
                         $time, bus.o_hour, bus.o_min, bus.o_sec, bus.o_tick, bus.o_alarm_ring,
                         bus.o_ring_idx, bus.o_alarm_en, eh, em, es, etick, m_ringing, eidx, een);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs; pulse inputs drop after the sampling edge.
    task automatic applyStimulus(input logic [1:0] mode, input logic [1:0] pos, input logic inc,
                                 input logic [1:0] sel, input logic tog, input logic snz,
                                 input logic stp);
        bus.i_mode         = mode;
        bus.i_position     = pos;
        bus.i_inc          = inc;
        bus.i_alarm_sel    = sel;
        bus.i_alarm_toggle = tog;
        bus.i_snooze       = snz;
        bus.i_stop         = stp;
        @(posedge clk); #1;
        bus.i_inc          = 1'b0;
        bus.i_alarm_toggle = 1'b0;
        bus.i_snooze       = 1'b0;
        bus.i_stop         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic setTime(input int h, input int m, input int s);
        int n;
        applyStimulus(2'd1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        n = (h - m_time / 3600 + 24) % 24;
        repeat (n) applyStimulus(2'd1, 2'd2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        n = (m - (m_time / 60) % 60 + 60) % 60;
        repeat (n) applyStimulus(2'd1, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        n = (s - m_time % 60 + 60) % 60;
        repeat (n) applyStimulus(2'd1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic waitRing(input string name, input int budget);
        int n;
        n = 0;
        while (!bus.o_alarm_ring && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!bus.o_alarm_ring) begin
            errors++;
            $display("[TB] FAIL %s: ring not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic countRing(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (bus.o_alarm_ring) n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tick_cnt, rings;
        bus.i_mode = 2'd0; bus.i_position = 2'd3; bus.i_inc = 1'b0; bus.i_alarm_sel = 2'd0;
        bus.i_alarm_toggle = 1'b0; bus.i_snooze = 1'b0; bus.i_stop = 1'b0;
        rst_n = 1'b0;
        idle(2);
        checkOutput("reset_time", int'({bus.o_hour, bus.o_min, bus.o_sec}), 0);
        checkOutput("reset_en", int'(bus.o_alarm_en), 0);
        checkOutput("reset_ring", int'(bus.o_alarm_ring), 0);
        rst_n = 1'b1;

        $display("[TB] rollover");
        setTime(23, 59, 58);
        checkOutput("set_hour", int'(bus.o_hour), 23);
        checkOutput("set_sec", int'(bus.o_sec), 58);
        bus.i_mode = 2'd0;
        tick_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.o_tick) tick_cnt++;
        end
        @(posedge clk); #1;
        checkOutput("rollover_time", int'({bus.o_hour, bus.o_min, bus.o_sec}), 0);
        checkOutput("rollover_ticks", tick_cnt, 2);

        $display("[TB] priority");
        repeat (7) applyStimulus(2'd2, 2'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd2, 2'd3, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        repeat (7) applyStimulus(2'd2, 2'd2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd2, 2'd3, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("alarm2_hour", int'(bus.o_hour), 7);
        checkOutput("en_after_setup", int'(bus.o_alarm_en), 6);
        setTime(6, 59, 59);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        waitRing("priority_ring", 20);
        checkOutput("priority_idx", int'(bus.o_ring_idx), 1);
        checkOutput("priority_time", int'(bus.o_hour) * 3600 + int'(bus.o_min) * 60 + int'(bus.o_sec), 7 * 3600);
        idle(11);
        checkOutput("ring_before_timeout", int'(bus.o_alarm_ring), 1);
        idle(1);
        checkOutput("ring_after_timeout", int'(bus.o_alarm_ring), 0);
        checkOutput("timeout_sec", int'(bus.o_sec), 3);

        $display("[TB] snooze");
        setTime(6, 59, 59);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        waitRing("snooze_first_ring", 20);
        idle(4);
        checkOutput("snooze_at_sec", int'(bus.o_sec), 1);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("ring_after_snooze", int'(bus.o_alarm_ring), 0);
        waitRing("snooze_reRing", 1300);
        checkOutput("snooze_min", int'(bus.o_min), 5);
        checkOutput("snooze_sec", int'(bus.o_sec), 0);
        checkOutput("snooze_idx", int'(bus.o_ring_idx), 1);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        checkOutput("ring_after_stop", int'(bus.o_alarm_ring), 0);
        countRing(1300, rings);
        checkOutput("no_ring_at_0710", rings, 0);

        $display("[TB] stop_vs_snooze");
        setTime(6, 59, 59);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        waitRing("stop_snooze_ring", 20);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("ring_after_both", int'(bus.o_alarm_ring), 0);
        countRing(1300, rings);
        checkOutput("no_ring_at_0705", rings, 0);

        $display("[TB] edit_boundaries");
        applyStimulus(2'd2, 2'd3, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'd2, 2'd3, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
        checkOutput("en_cleared", int'(bus.o_alarm_en), 0);
        repeat (25) applyStimulus(2'd2, 2'd2, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("alarm3_display", int'({bus.o_hour, bus.o_min, bus.o_sec}), 1 << 12);
        applyStimulus(2'd2, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
        checkOutput("pos0_ignored", int'({bus.o_hour, bus.o_min, bus.o_sec}), 1 << 12);
        applyStimulus(2'd2, 2'd3, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("en_alarm3", int'(bus.o_alarm_en), 8);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
        checkOutput("toggle_outside_mode2", int'(bus.o_alarm_en), 8);
        applyStimulus(2'd3, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        setTime(1, 0, 0);
        idle(3);
        checkOutput("edit_no_ring", int'(bus.o_alarm_ring), 0);
        checkOutput("edit_time", int'({bus.o_hour, bus.o_min, bus.o_sec}), 1 << 12);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        countRing(8, rings);
        checkOutput("run_no_ring", rings, 0);

        $display("[TB] reset_mid_ring");
        setTime(0, 59, 59);
        applyStimulus(2'd0, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        waitRing("alarm3_ring", 20);
        checkOutput("alarm3_idx", int'(bus.o_ring_idx), 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_time", int'({bus.o_hour, bus.o_min, bus.o_sec}), 0);
        checkOutput("rst_ring", int'(bus.o_alarm_ring), 0);
        checkOutput("rst_idx", int'(bus.o_ring_idx), 0);
        checkOutput("rst_en", int'(bus.o_alarm_en), 0);
        checkOutput("rst_tick", int'(bus.o_tick), 0);
        rst_n = 1'b1;
        idle(3);
        checkOutput("first_tick_after_reset", int'(bus.o_tick), 1);
        idle(1);
        checkOutput("sec_after_first_tick", int'(bus.o_sec), 1);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multi_alarm_clock_core.md
# multi_alarm_clock_core

- Parametrised timekeeping core: the next generation of the single-alarm clock datapath.
- Generates the 1 Hz tick from `clk` and keeps hour/min/sec.
- Holds `NUM_ALARMS` independently enabled alarms and adds snooze and an auto-timeout ring.
- Sits between the switch/debounce controller (mode, position and pulse inputs) and the digit-split/blink/segment display chain plus buzzer.

## Interface

Parameters:
- `CLK_HZ`, 1000: `clk` cycles per second (≥2).
- `NUM_ALARMS`, 4: number of alarm registers (1..16).
- `SNOOZE_MIN`, 5: snooze delay in minutes (1..59).
- `RING_SEC`, 60: seconds before an unacknowledged ring self-clears (1..255).

Ports (IW = max(1, clog2(NUM_ALARMS))):
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — reset, synchronous, active-low.
- `i_mode`  in  2  — 0 clock, 1 set time, 2 set alarm, 3 treated as 0.
- `i_position`  in  2  — field select: 0 sec, 1 min, 2 hour, 3 none.
- `i_inc`  in  1  — one-cycle pulse: increment the selected field.
- `i_alarm_sel`  in  IW  — alarm index edited/displayed in mode 2.
- `i_alarm_toggle`  in  1  — pulse: invert the enable of `i_alarm_sel` (mode 2 only).
- `i_snooze`  in  1  — pulse: snooze an active ring.
- `i_stop`  in  1  — pulse: stop the ring and cancel a pending snooze.
- `o_hour`, `o_min`, `o_sec`  out  6 each  — display value: time in modes 0/1/3; selected alarm HH:MM:00 in mode 2.
- `o_tick`  out  1  — high for the one cycle in which time advances.
- `o_alarm_ring`  out  1  — buzzer enable.
- `o_ring_idx`  out  IW  — alarm index that caused the current ring.
- `o_alarm_en`  out  NUM_ALARMS  — per-alarm enable mask.

## Operation

Prescaler:
- Counts 0..CLK_HZ-1. Tick = running AND count==CLK_HZ-1.
- Running in modes 0/2/3.
- In mode 1 the prescaler is held at 0 and time is frozen.

Time advance on tick:
- sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0.

Set time (mode 1, `i_inc`):
- Selected field +1 with wrap (sec/min 59→0, hour 23→0). No carry into other fields.
- Position 3 is ignored.

Set alarm (mode 2, `i_inc`):
- Edits `alarm[i_alarm_sel]` min or hour with the same wrap rules.
- Position 0 and position 3 are ignored.
- `i_alarm_sel` ≥ NUM_ALARMS is ignored for edit and toggle; display then shows 00:00:00.

Ignored inputs:
- `i_inc` in mode 0/3 is ignored.
- `i_alarm_toggle` outside mode 2 is ignored.

Alarm trigger:
- Evaluated only on a tick whose new time is HH:MM:00.
- Any enabled alarm matching HH:MM starts a ring; the lowest matching index wins and is latched into `o_ring_idx`.
- Matches while already ringing are ignored.
- Time edits in mode 1 never trigger.

Ring states: IDLE, RING, SNOOZED.
- IDLE→RING on trigger; ring counter cleared.
- RING→IDLE on `i_stop`, or on the tick that brings the ring counter to RING_SEC.
- RING→SNOOZED on `i_snooze`:
  - Target = current time + SNOOZE_MIN minutes (min mod 60, carry to hour mod 24), seconds 0.
  - `o_ring_idx` is retained.
- SNOOZED→RING when a tick produces target:00. Ring counter cleared.
- SNOOZED→IDLE on `i_stop`.
- While SNOOZED, a normal alarm match takes priority: →RING with the new index, pending snooze discarded.

Simultaneous events:
- `i_stop` and `i_snooze` in the same cycle: stop wins.
- Toggling off the ringing alarm does not stop the ring.
- `i_inc` coinciding with a tick in mode 2 applies both.

## Timing

- Reset values (first edge with `rst_n`=0):
  - prescaler 0, time 00:00:00.
  - All alarms 00:00 and disabled: `o_alarm_en`=0.
  - State IDLE: `o_alarm_ring`=0, `o_ring_idx`=0, `o_tick`=0.
- Reset mid-ring or mid-snooze clears everything at that edge.
- `o_tick` is combinational, high during the cycle before the edge that updates the time registers.
- After reset or on leaving mode 1, the first tick occurs CLK_HZ cycles later.
- Ring latency: `o_alarm_ring` rises on the same edge the time registers become HH:MM:00. `o_ring_idx` is valid on that edge.
- `i_stop` / `i_snooze` take effect on the next edge; the ring falls one cycle after the pulse.
- `i_inc` / `i_alarm_toggle`: register updated on the next edge; outputs show the new value the following cycle.
- `o_hour` / `o_min` / `o_sec` are registered or combinational from registers only; mode-change mux latency is 0 cycles.

## Test plan

All scenarios use CLK_HZ=4, NUM_ALARMS=4, SNOOZE_MIN=5, RING_SEC=3.

1. **Rollover:** reset, set 23:59:58 in mode 1, switch to mode 0 → after 8 cycles shows 00:00:00; `o_tick` seen exactly twice.
2. **Priority:** alarms 1 and 2 both 07:00 and enabled, time 06:59:59 → at the next tick ring=1, idx=1; ring drops 3 ticks later without stop.
3. **Snooze:** ring at 07:00:00, `i_snooze` at 07:00:01 → ring low; ring rises at 07:05:00, idx unchanged; `i_stop` → low; nothing at 07:10:00.
4. **Stop vs snooze:** `i_stop` and `i_snooze` same cycle during ring → IDLE, no ring at +5 min.
5. **Edit boundaries:** mode 2, sel=3, inc hour ×25 → 01; inc at position 0 → unchanged; toggle → `o_alarm_en`=4'b1000; mode 1 set time to 01:00:00 → no ring.
6. **Reset mid-ring:** `rst_n`=0 for one cycle while ringing → all outputs at reset values on that edge; `o_alarm_en`=0.
